// File: rtl/cof_pkg.sv
// Shared widths, table-word slot offsets and FSM/slot-mode enums for the
// coefficient packer.
package cof_pkg;
    localparam int I_EXP_WIDTH = 5;
    localparam int O_EXP_WIDTH = 8;
    localparam int FRAC_W_HI   = 40;
    localparam int FRAC_W_LO   = 36;
    localparam int ADDR_WIDTH  = 6;
    localparam int WORD_W      = 168;

    // {exp msb, frac msb, slot lsb} for each slot of the 168b table word
    localparam int C0_EXP_MSB = 167, C0_FRAC_MSB = 162, C0_LSB = 124;
    localparam int C1_EXP_MSB = 123, C1_FRAC_MSB = 118, C1_LSB = 80;
    localparam int C2_EXP_MSB = 79,  C2_FRAC_MSB = 74,  C2_LSB = 40;
    localparam int C3_EXP_MSB = 39,  C3_FRAC_MSB = 34,  C3_LSB = 0;

    typedef enum logic {FILL, HOLD} state_t;

    // EXP_NEG: exponent must lie in -32..-1; EXP_SIGNED: -16..15
    typedef enum logic {EXP_SIGNED, EXP_NEG} exp_chk_t;
    typedef enum logic [1:0] {SIGN_ANY, SIGN_POS, SIGN_NEG} sign_chk_t;
endpackage

// File: rtl/cof_cmp_slot.sv
// Combinational compressor for one coefficient slot: packs exp/frac into the
// table field and flags values that recovery could not reproduce.
module cof_cmp_slot
    import cof_pkg::*;
#(
    parameter int        FRAC_W    = FRAC_W_HI,
    parameter exp_chk_t  EXP_MODE  = EXP_SIGNED,
    parameter sign_chk_t SIGN_MODE = SIGN_ANY
) (
    input  logic                          sign,
    input  logic [O_EXP_WIDTH-1:0]        exp,
    input  logic [FRAC_W_HI-1:0]          frac,
    output logic [I_EXP_WIDTH+FRAC_W-2:0] field,
    output logic                          err,
    output logic                          inexact
);
    localparam int DROP = FRAC_W_HI - FRAC_W;
    localparam logic [FRAC_W_HI-1:0] LO_MASK = ~({FRAC_W_HI{1'b1}} << DROP);

    logic exp_err;
    logic sign_err;

    always_comb begin
        if (EXP_MODE == EXP_NEG)
            exp_err = (exp[7:5] != 3'b111);
        else
            exp_err = (exp[7:5] != {3{exp[4]}});

        case (SIGN_MODE)
            SIGN_POS: sign_err = sign;
            SIGN_NEG: sign_err = ~sign;
            default:  sign_err = 1'b0;
        endcase

        // hidden bit is implied by recovery, so it is dropped from the field
        field   = {exp[I_EXP_WIDTH-1:0], frac[FRAC_W_HI-2 -: FRAC_W-1]};
        err     = exp_err | sign_err | ~frac[FRAC_W_HI-1];
        inexact = |(frac & LO_MASK);
    end
endmodule

// File: rtl/cof_pack.sv
// Collects four coefficients c0..c3, packs them into one 168b table word and
// hands the word out with its table address and error flags.
module cof_pack
    import cof_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [O_EXP_WIDTH-1:0] in_exp,
    input  logic [FRAC_W_HI-1:0]   in_frac,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      cof_packed,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [3:0]             out_err,
    output logic                   out_inexact
);
    state_t     state;
    logic [1:0] slot;

    logic [I_EXP_WIDTH+FRAC_W_HI-2:0] f0, f1;
    logic [I_EXP_WIDTH+FRAC_W_LO-2:0] f2, f3;
    logic [3:0] s_err, s_inx;

    cof_cmp_slot #(.FRAC_W(FRAC_W_HI), .EXP_MODE(EXP_NEG), .SIGN_MODE(SIGN_POS)) u_c0 (
        .sign(in_sign), .exp(in_exp), .frac(in_frac), .field(f0), .err(s_err[0]), .inexact(s_inx[0]));
    cof_cmp_slot #(.FRAC_W(FRAC_W_HI), .EXP_MODE(EXP_SIGNED), .SIGN_MODE(SIGN_ANY)) u_c1 (
        .sign(in_sign), .exp(in_exp), .frac(in_frac), .field(f1), .err(s_err[1]), .inexact(s_inx[1]));
    cof_cmp_slot #(.FRAC_W(FRAC_W_LO), .EXP_MODE(EXP_SIGNED), .SIGN_MODE(SIGN_NEG)) u_c2 (
        .sign(in_sign), .exp(in_exp), .frac(in_frac), .field(f2), .err(s_err[2]), .inexact(s_inx[2]));
    cof_cmp_slot #(.FRAC_W(FRAC_W_LO), .EXP_MODE(EXP_SIGNED), .SIGN_MODE(SIGN_ANY)) u_c3 (
        .sign(in_sign), .exp(in_exp), .frac(in_frac), .field(f3), .err(s_err[3]), .inexact(s_inx[3]));

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            slot        <= 2'd0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            // NOTE: the word register is a plain flop bank, not a RAM, so it is
            // reset to keep unwritten slots from ever showing X.
            cof_packed  <= '0;
            out_addr    <= '0;
            out_err     <= 4'd0;
            out_inexact <= 1'b0;
        end else if (clr) begin
            state       <= FILL;
            slot        <= 2'd0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_err     <= 4'd0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                FILL: if (in_valid) begin
                    case (slot)
                        2'd0:    cof_packed[C0_EXP_MSB:C0_LSB] <= f0;
                        2'd1:    cof_packed[C1_EXP_MSB:C1_LSB] <= f1;
                        2'd2:    cof_packed[C2_EXP_MSB:C2_LSB] <= f2;
                        default: cof_packed[C3_EXP_MSB:C3_LSB] <= f3;
                    endcase
                    out_err[slot] <= s_err[slot];
                    out_inexact   <= out_inexact | s_inx[slot];
                    slot          <= slot + 2'd1;
                    if (slot == 2'd3) begin
                        state     <= HOLD;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: if (out_ready) begin
                    state       <= FILL;
                    slot        <= 2'd0;
                    in_ready    <= 1'b1;
                    out_valid   <= 1'b0;
                    out_addr    <= out_addr + 1'b1;
                    out_err     <= 4'd0;
                    out_inexact <= 1'b0;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_cof_pack.sv
// Directed bench for cof_pack: packing, recovery round-trip, error flags,
// backpressure, address wrap, clr and async reset.
module tb_cof_pack;
    import cof_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_sign = 1'b0;
    logic [7:0]   in_exp = '0;
    logic [39:0]  in_frac = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [167:0] cof_packed;
    logic [5:0]   out_addr;
    logic [3:0]   out_err;
    logic         out_inexact;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [39:0] f;
    } coef_t;

    cof_pack dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac),
        .out_valid(out_valid), .out_ready(out_ready),
        .cof_packed(cof_packed), .out_addr(out_addr),
        .out_err(out_err), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [167:0] got, input logic [167:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    function automatic coef_t mk(input logic s, input logic [7:0] e, input logic [39:0] f);
        mk.s = s; mk.e = e; mk.f = f;
    endfunction

    // All tasks start and end on a falling edge.
    task automatic send(input coef_t c, input logic with_clr);
        int n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) check("send_ready_timeout", in_ready, 1);
        in_valid = 1'b1; in_sign = c.s; in_exp = c.e; in_frac = c.f; clr = with_clr;
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic send_word(input coef_t a, input coef_t b, input coef_t c, input coef_t d);
        send(a, 1'b0); send(b, 1'b0); send(c, 1'b0); send(d, 1'b0);
    endtask

    task automatic wait_word(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check({tag, "_valid"}, out_valid, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Inverse of packing as the recovery stage performs it.
    task automatic check_recovery(input string tag, input coef_t a, input coef_t b,
                                  input coef_t c, input coef_t d);
        check({tag, "_e0"}, {3'b111, cof_packed[167:163]}, a.e);
        check({tag, "_f0"}, {1'b1, cof_packed[162:124]}, a.f);
        check({tag, "_e1"}, {{3{cof_packed[123]}}, cof_packed[123:119]}, b.e);
        check({tag, "_f1"}, {1'b1, cof_packed[118:80]}, b.f);
        check({tag, "_e2"}, {{3{cof_packed[79]}}, cof_packed[79:75]}, c.e);
        check({tag, "_f2"}, {1'b1, cof_packed[74:40], 4'h0}, c.f);
        check({tag, "_e3"}, {{3{cof_packed[39]}}, cof_packed[39:35]}, d.e);
        check({tag, "_f3"}, {1'b1, cof_packed[34:0], 4'h0}, d.f);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_packed"}, cof_packed, 168'd0);
        check({tag, "_addr"}, out_addr, 6'd0);
        check({tag, "_err"}, out_err, 4'd0);
        check({tag, "_inexact"}, out_inexact, 0);
    endtask

    coef_t t1_0, t1_1, t1_2, t1_3;
    coef_t t2_0, t2_1, t2_2, t2_3;
    coef_t t3_0, t3_1, t3_2, t3_3;
    coef_t b0, b1, b2, b3;
    coef_t g0, g1, g2, g3;

    initial begin
        t1_0 = mk(1'b0, 8'hFD, 40'h80_0000_0001);
        t1_1 = mk(1'b1, 8'h02, 40'hC0_0000_0000);
        t1_2 = mk(1'b1, 8'hF9, 40'hA5_5555_5550);
        t1_3 = mk(1'b0, 8'h0F, 40'hFF_FFFF_FFF0);
        t2_0 = mk(1'b0, 8'h01, 40'h80_0000_0000);
        t2_1 = mk(1'b0, 8'h10, 40'h80_0000_0000);
        t2_2 = mk(1'b1, 8'hF0, 40'h80_0000_0000);
        t2_3 = mk(1'b0, 8'h00, 40'h80_0000_0000);
        t3_0 = mk(1'b1, 8'hFF, 40'h80_0000_0000);
        t3_1 = mk(1'b1, 8'h00, 40'h80_0000_0000);
        t3_2 = mk(1'b0, 8'h00, 40'h80_0000_0005);
        t3_3 = mk(1'b0, 8'h00, 40'h40_0000_0000);
        b0 = mk(1'b0, 8'hE0, 40'h81_2345_6789);
        b1 = mk(1'b0, 8'hF1, 40'h9A_BCDE_F012);
        b2 = mk(1'b1, 8'h07, 40'hDE_ADBE_EF00);
        b3 = mk(1'b1, 8'hF8, 40'hB0_0000_0010);

        // reset
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // T1: clean word, exp fields and round trip
        send_word(t1_0, t1_1, t1_2, t1_3);
        wait_word("t1");
        check("t1_exp0", cof_packed[167:163], 5'h1D);
        check("t1_exp1", cof_packed[123:119], 5'h02);
        check("t1_exp2", cof_packed[79:75], 5'h19);
        check("t1_exp3", cof_packed[39:35], 5'h0F);
        check("t1_err", out_err, 4'd0);
        check("t1_inexact", out_inexact, 0);
        check("t1_addr", out_addr, 6'd0);
        check("t1_in_ready", in_ready, 0);
        check_recovery("t1", t1_0, t1_1, t1_2, t1_3);
        consume();
        check("t1_addr_next", out_addr, 6'd1);
        check("t1_drain_valid", out_valid, 0);
        check("t1_drain_ready", in_ready, 1);

        // T2: exponent range errors, word still emitted
        send_word(t2_0, t2_1, t2_2, t2_3);
        wait_word("t2");
        check("t2_err", out_err, 4'b0011);
        check("t2_exp0_low", cof_packed[167:163], 5'h01);
        check("t2_exp1_low", cof_packed[123:119], 5'h10);
        check("t2_exp2", cof_packed[79:75], 5'h10);
        consume();
        check("t2_addr", out_addr, 6'd2);

        // T3: sign and hidden-bit errors, truncation flag
        send_word(t3_0, t3_1, t3_2, t3_3);
        wait_word("t3");
        check("t3_err", out_err, 4'b1101);
        check("t3_inexact", out_inexact, 1);
        check("t3_frac2", cof_packed[74:40], 35'h0);
        check("t3_frac3", cof_packed[34:0], 35'h4_0000_0000);
        consume();
        check("t3_addr", out_addr, 6'd3);
        check("t3_err_cleared", out_err, 4'd0);
        check("t3_inexact_cleared", out_inexact, 0);

        // T5: clr in HOLD, then clr coincident with the 3rd handshake
        send_word(b0, b1, b2, b3);
        wait_word("t5a");
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t5_hold_clr_valid", out_valid, 0);
        check("t5_hold_clr_addr", out_addr, 6'd0);
        check("t5_hold_clr_ready", in_ready, 1);
        send(t3_0, 1'b0); send(t3_1, 1'b0); send(t3_2, 1'b1);
        check("t5_mid_clr_err", out_err, 4'd0);
        send_word(b0, b1, b2, b3);
        wait_word("t5b");
        check_recovery("t5", b0, b1, b2, b3);
        check("t5_err", out_err, 4'd0);
        check("t5_addr", out_addr, 6'd0);
        consume();
        check("t5_addr_next", out_addr, 6'd1);

        // T4: backpressure with extra input ignored, then address wrap
        send_word(t1_0, t1_1, t1_2, t1_3);
        wait_word("t4");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h55; in_frac = 40'h12_3456_789A;
            @(negedge clk);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        check_recovery("t4", t1_0, t1_1, t1_2, t1_3);
        check("t4_addr_before", out_addr, 6'd1);
        consume();
        check("t4_addr_after", out_addr, 6'd2);
        for (int i = 0; i < 62; i++) begin
            g0 = mk(1'b0, 8'hE0 + 8'(i % 32), 40'h80_0000_0000 + 40'(i));
            g1 = mk(1'b1, 8'(i % 16), 40'h90_0000_0000 + 40'(i));
            g2 = mk(1'b1, 8'hF0 + 8'(i % 16), 40'hA0_0000_0000 + 40'(i * 16));
            g3 = mk(1'b0, 8'h03, 40'hF0_0000_0000 + 40'(i * 16));
            send_word(g0, g1, g2, g3);
            wait_word("wrap");
            if (i == 61) begin
                check_recovery("wrap_last", g0, g1, g2, g3);
                check("wrap_addr_63", out_addr, 6'd63);
            end
            consume();
        end
        check("wrap_addr_0", out_addr, 6'd0);

        // T6: async reset after two accepts
        send(t3_0, 1'b0); send(t3_1, 1'b0);
        rst_n = 1'b0;
        #2;
        check_idle("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(t1_0, t1_1, t1_2, t1_3);
        wait_word("t6");
        check_recovery("t6", t1_0, t1_1, t1_2, t1_3);
        check("t6_err", out_err, 4'd0);
        check("t6_addr", out_addr, 6'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
